// File: rtl/resp_frame_tx.sv
// Response framer: serialises MAGIC, STATUS, LEN, PAYLOAD, CRC8 onto the uart_tx byte handshake.
// One request is framed at a time. The frame is aborted on a per-byte timeout or on an external abort.
module resp_frame_tx #(
    parameter logic [7:0] MAGIC_BYTE     = 8'hA5,
    parameter logic [7:0] CRC8_POLY      = 8'h07,
    parameter int         MAX_PAYLOAD    = 16,
    parameter int         TX_TIMEOUT_CYC = 1350000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_status,
    input  logic [7:0]               req_len,
    input  logic [8*MAX_PAYLOAD-1:0] req_payload_flat,
    input  logic                     abort,
    output logic                     tx_dv,
    output logic [7:0]               tx_byte,
    input  logic                     tx_active,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout
);

    localparam int                IDX_W    = $clog2(MAX_PAYLOAD + 4);
    localparam int                TMR_W    = $clog2(TX_TIMEOUT_CYC + 1);
    localparam logic [7:0]        MAX_LEN  = 8'(MAX_PAYLOAD);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TX_TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        FINISH    = 2'd3
    } state_t;

    state_t                   state_r, state_next_s;
    logic [7:0]               status_r, len_r, crc_r, tx_byte_r;
    logic [8*MAX_PAYLOAD-1:0] payload_r;
    logic [IDX_W-1:0]         idx_r, crc_idx_s, pidx_s;
    logic [TMR_W-1:0]         timer_r;
    logic                     tx_dv_r, done_r, err_timeout_r;
    logic                     accept_s, issue_s, advance_s, finish_s, expire_s, fold_s;
    logic [7:0]               cur_byte_s, pay_byte_s;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign req_ready   = (state_r == IDLE);
    assign busy        = (state_r != IDLE);
    assign tx_dv       = tx_dv_r;
    assign tx_byte     = tx_byte_r;
    assign done        = done_r;
    assign err_timeout = err_timeout_r;

    // Select the byte for the current index; the CRC slot sits right after the last payload byte
    always_comb begin
        crc_idx_s  = IDX_W'(len_r) + IDX_W'(3);
        pidx_s     = idx_r - IDX_W'(3);
        pay_byte_s = 8'h00;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (pidx_s == IDX_W'(i)) begin
                pay_byte_s = payload_r[8*i +: 8];
            end else begin
                pay_byte_s = pay_byte_s;
            end
        end
        if (idx_r == IDX_W'(0)) begin
            cur_byte_s = MAGIC_BYTE;
        end else if (idx_r == IDX_W'(1)) begin
            cur_byte_s = status_r;
        end else if (idx_r == IDX_W'(2)) begin
            cur_byte_s = len_r;
        end else if (idx_r == crc_idx_s) begin
            cur_byte_s = crc_r;
        end else begin
            cur_byte_s = pay_byte_s;
        end
        fold_s = (idx_r != IDX_W'(0)) && (idx_r != crc_idx_s);
    end

    // Next-state logic; abort outranks tx_done, and tx_done outranks timer expiry
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        advance_s    = 1'b0;
        finish_s     = 1'b0;
        expire_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_next_s = IDLE;
                end else if (!tx_active) begin
                    issue_s      = 1'b1;
                    state_next_s = WAIT_DONE;
                end else if (timer_r == TMR_LAST) begin
                    expire_s     = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            WAIT_DONE: begin
                if (abort) begin
                    state_next_s = IDLE;
                end else if (tx_done) begin
                    advance_s = 1'b1;
                    if (idx_r == crc_idx_s) begin
                        finish_s     = 1'b1;
                        state_next_s = FINISH;
                    end else begin
                        state_next_s = ISSUE;
                    end
                end else if (timer_r == TMR_LAST) begin
                    expire_s     = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            FINISH: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered strobes toward uart_tx and the upstream FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_dv_r       <= 1'b0;
            tx_byte_r     <= 8'h00;
            done_r        <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            tx_dv_r       <= issue_s;
            done_r        <= finish_s;
            err_timeout_r <= expire_s;
            if (issue_s) begin
                tx_byte_r <= cur_byte_s;
            end else begin
                tx_byte_r <= tx_byte_r;
            end
        end
    end

    // Request capture, byte index and running CRC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_r  <= 8'h00;
            len_r     <= 8'h00;
            payload_r <= {(8*MAX_PAYLOAD){1'b0}};
            crc_r     <= 8'h00;
            idx_r     <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            status_r  <= req_status;
            len_r     <= (req_len > MAX_LEN) ? MAX_LEN : req_len;
            payload_r <= req_payload_flat;
            crc_r     <= 8'h00;
            idx_r     <= {IDX_W{1'b0}};
        end else begin
            if (issue_s && fold_s) begin
                crc_r <= crc8_update(crc_r, cur_byte_s);
            end else begin
                crc_r <= crc_r;
            end
            if (advance_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Per-byte watchdog: restarts on each strobe, idles at zero outside ISSUE/WAIT_DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r <= {TMR_W{1'b0}};
        end else if ((state_r == ISSUE || state_r == WAIT_DONE) && !issue_s && (state_next_s != IDLE)) begin
            timer_r <= timer_r + TMR_W'(1);
        end else begin
            timer_r <= {TMR_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_resp_frame_tx.sv
// Scoreboard bench for resp_frame_tx: a uart_tx model answers each strobe, and a monitor checks bytes and pulses.
module tb_resp_frame_tx;

    localparam int MAXP   = 16;
    localparam int TMO    = 100;
    localparam int N_DONE = 3;
    localparam int EV_DONE = 1;
    localparam int EV_TMO  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_status;
    logic [7:0]        req_len;
    logic [8*MAXP-1:0] req_payload_flat;
    logic              abort;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              tx_active;
    logic              tx_done;
    logic              busy;
    logic              done;
    logic              err_timeout;

    resp_frame_tx #(
        .MAGIC_BYTE(8'hA5), .CRC8_POLY(8'h07), .MAX_PAYLOAD(MAXP), .TX_TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_status(req_status), .req_len(req_len), .req_payload_flat(req_payload_flat),
        .abort(abort), .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active),
        .tx_done(tx_done), .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int         ev_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         dv_cnt = 0;
    int         last_dv_cyc = 0;
    int         done_cyc = 0;
    int         acc_cyc = 0;
    int         model_cnt = 0;
    int         withhold_at = 0;
    int         extra_active = 0;
    logic       act_prev = 1'b0;
    logic       chk_ready = 1'b0;
    logic [7:0] exp_b;
    int         exp_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_model(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ d[b];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] st, input int le, input logic [8*MAXP-1:0] pl);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(st);
        exp_q.push_back(8'(le));
        c = crc_model(c, st);
        c = crc_model(c, 8'(le));
        for (int i = 0; i < le; i++) begin
            b = pl[8*i +: 8];
            exp_q.push_back(b);
            c = crc_model(c, b);
        end
        exp_q.push_back(c);
    endtask

    task automatic ev_pop(input int got);
        if (ev_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got event %0d expected none", got);
        end else begin
            exp_ev = ev_q.pop_front();
            check("event_kind", got, exp_ev);
        end
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // uart_tx model: tx_done N_DONE cycles after each strobe, optional stretched tx_active or withheld done
    initial begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv === 1'b1 && rst === 1'b0) begin
                model_cnt++;
                if (!(withhold_at != 0 && model_cnt == withhold_at)) begin
                    tx_active = 1'b1;
                    repeat (N_DONE) @(posedge clk);
                    #1;
                    tx_done = 1'b1;
                    if (extra_active == 0) tx_active = 1'b0;
                    @(posedge clk);
                    #1;
                    tx_done = 1'b0;
                    if (extra_active != 0) begin
                        repeat (extra_active) @(posedge clk);
                        #1;
                        tx_active = 1'b0;
                    end
                end
            end
        end
    end

    // monitor: pops the scoreboard on every strobe/pulse
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            if (chk_ready) begin
                check("ready_after_done", {30'd0, busy, req_ready}, 32'd1);
                chk_ready = 1'b0;
            end
            if (tx_dv === 1'b1) begin
                dv_cnt++;
                check("dv_while_active", {31'd0, act_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_tx_dv: got byte %h expected none", tx_byte);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_b});
                end
                last_dv_cyc = cyc;
            end
            if (done === 1'b1) begin
                done_cyc  = cyc;
                chk_ready = 1'b1;
                ev_pop(EV_DONE);
            end
            if (err_timeout === 1'b1) begin
                ev_pop(EV_TMO);
                check("timeout_latency", cyc - last_dv_cyc, TMO);
                check("ready_at_timeout", {31'd0, req_ready}, 32'd1);
            end
        end
        act_prev = tx_active;
    end

    task automatic send(input logic [7:0] st, input logic [7:0] len, input logic [8*MAXP-1:0] pl);
        model_cnt = 0;
        dv_cnt    = 0;
        @(posedge clk);
        #1;
        req_status       = st;
        req_len          = len;
        req_payload_flat = pl;
        req_valid        = 1'b1;
        acc_cyc          = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_hang: busy still 1 after %0d cycles, expected 0", name, n);
        end
        repeat (8) @(posedge clk);
    endtask

    task automatic wait_model(input int k, input string name);
        int n;
        n = 0;
        while (model_cnt < k && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_wait: saw %0d strobes expected %0d", name, model_cnt, k);
        end
    endtask

    task automatic end_test(input string name);
        check({name, "_bytes_left"}, exp_q.size(), 0);
        check({name, "_events_left"}, ev_q.size(), 0);
    endtask

    logic [8*MAXP-1:0] pl;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_status = 8'h00; req_len = 8'h00;
        req_payload_flat = '0; abort = 1'b0;
        @(negedge clk);
        check("reset_outputs", {23'd0, tx_dv, tx_byte, busy, done, err_timeout, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // status 01, no payload
        exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h15);
        ev_q.push_back(EV_DONE);
        send(8'h01, 8'd0, '0);
        wait_idle("t1");
        check("t1_dv_count", dv_cnt, 4);
        check("t1_latency", done_cyc - acc_cyc, 4 * (N_DONE + 2) + 1);
        end_test("t1");

        // status 02, one zero byte
        exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'hC3);
        ev_q.push_back(EV_DONE);
        send(8'h02, 8'd1, '0);
        wait_idle("t2");
        check("t2_dv_count", dv_cnt, 5);
        check("t2_latency", done_cyc - acc_cyc, 5 * (N_DONE + 2) + 1);
        end_test("t2");

        // oversize request clamps to 16 bytes
        for (int i = 0; i < MAXP; i++) pl[8*i +: 8] = 8'(i * 13 + 5);
        push_frame(8'h01, 16, pl);
        ev_q.push_back(EV_DONE);
        send(8'h01, 8'd20, pl);
        wait_idle("t3");
        check("t3_dv_count", dv_cnt, 20);
        check("t3_latency", done_cyc - acc_cyc, 20 * (N_DONE + 2) + 1);
        end_test("t3");

        // tx_active stretched 3 cycles past tx_done
        extra_active = 3;
        pl = '0;
        pl[7:0] = 8'h5A;
        pl[15:8] = 8'hC3;
        push_frame(8'hEE, 2, pl);
        ev_q.push_back(EV_DONE);
        send(8'hEE, 8'd2, pl);
        wait_idle("t4");
        check("t4_dv_count", dv_cnt, 6);
        end_test("t4");
        extra_active = 0;

        // tx_done withheld after the second byte
        withhold_at = 2;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h01);
        ev_q.push_back(EV_TMO);
        send(8'h01, 8'd0, '0);
        wait_idle("t5");
        check("t5_dv_count", dv_cnt, 2);
        end_test("t5");
        withhold_at = 0;

        // abort while payload byte 2 is in flight
        pl = '0;
        pl[31:0] = 32'h44332211;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h04);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        send(8'h00, 8'd4, pl);
        wait_model(6, "t6");
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("t6_after_abort", {28'd0, busy, done, err_timeout, req_ready}, 32'h1);
        repeat (20) @(posedge clk);
        end_test("t6");
        push_frame(8'hEF, 0, '0);
        ev_q.push_back(EV_DONE);
        send(8'hEF, 8'd0, '0);
        wait_idle("t6b");
        check("t6b_dv_count", dv_cnt, 4);
        end_test("t6b");

        // async reset in the middle of a frame
        exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h03);
        send(8'h01, 8'd3, pl);
        wait_model(3, "t7");
        #1;
        rst = 1'b1;
        #1;
        check("t7_reset_outputs", {23'd0, tx_dv, tx_byte, busy, done, err_timeout, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        end_test("t7");
        exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'hC3);
        ev_q.push_back(EV_DONE);
        send(8'h02, 8'd1, '0);
        wait_idle("t7b");
        check("t7b_dv_count", dv_cnt, 5);
        end_test("t7b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/resp_frame_tx.md
Name: resp_frame_tx

Overview:
- Downstream stage of the auth frame FSM. Turns one response request into a framed byte stream for the UART transmitter.
- Request fields: status byte plus an optional payload.
- Frame on the wire: MAGIC, STATUS, LEN, PAYLOAD[0..LEN-1], CRC8.
- CRC8 matches the host-to-FPGA frame format, so the host parses both directions with one routine.
- Drives the uart_tx byte handshake (i_Tx_DV / i_Tx_Byte / o_Tx_Active / o_Tx_Done) directly.

Parameters:
- MAGIC_BYTE, 8'hA5, first byte of every frame.
- CRC8_POLY, 8'h07, CRC polynomial; MSB-first, init 8'h00, no reflection, no final XOR.
- MAX_PAYLOAD, 16, payload capacity in bytes; also sets the width of req_payload_flat.
- TX_TIMEOUT_CYC, 1350000, cycles allowed per byte (50 ms at 27 MHz) before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  response request present.
- req_ready  out  1  block can accept a request.
- req_status  in  8  status byte (01/00/02/EE/EF codes).
- req_len  in  8  payload length requested.
- req_payload_flat  in  8*MAX_PAYLOAD  payload; byte i is at [8*i +: 8].
- abort  in  1  synchronous abort of the frame in progress (fpga_wake release).
- tx_dv  out  1  one-cycle strobe to uart_tx i_Tx_DV.
- tx_byte  out  8  byte to uart_tx i_Tx_Byte.
- tx_active  in  1  uart_tx o_Tx_Active.
- tx_done  in  1  uart_tx o_Tx_Done pulse.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse: frame fully transmitted.
- err_timeout  out  1  one-cycle pulse: frame aborted by timeout.

Behaviour:
- Reset (async, rst=1) forces all outputs to their reset values immediately, including mid-frame:
  - state=IDLE, req_ready=1 (combinational from IDLE), tx_dv=0, tx_byte=00, busy=0, done=0, err_timeout=0, internal crc=00, idx=0, timer=0.
- States: IDLE, ISSUE, WAIT_DONE, FINISH.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch status, payload and len_eff = min(req_len, MAX_PAYLOAD). The LEN byte on the wire is len_eff.
  - Clear crc and idx, then go to ISSUE.
- Byte index sequence:
  - idx0=MAGIC, idx1=STATUS, idx2=LEN.
  - idx3..idx(2+len_eff)=payload bytes 0..len_eff-1.
  - Final index = CRC.
  - len_eff=0 goes straight from LEN to CRC.
- ISSUE:
  - When tx_active==0, drive tx_byte with the current byte and pulse tx_dv high for exactly one cycle.
  - In the same cycle, fold the byte into crc if it is STATUS, LEN or payload. MAGIC and CRC are not folded.
  - Go to WAIT_DONE and reset the timer.
- WAIT_DONE:
  - On tx_done, increment idx. If the CRC byte was just sent, go to FINISH; otherwise go to ISSUE.
  - The WAIT_DONE->ISSUE hop guarantees at least one idle cycle between tx_done and the next tx_dv.
- FINISH: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- tx_byte holds its last value between strobes.
- CRC: the byte-wise update is fully combinational within one cycle; an 8-iteration shift loop is acceptable.
- Timeout:
  - The timer counts every cycle in ISSUE and WAIT_DONE and resets on each tx_dv.
  - When timer reaches TX_TIMEOUT_CYC: err_timeout=1 for one cycle, go to IDLE, no done pulse.
- abort=1 in any non-IDLE state:
  - Go to IDLE next cycle with no done and no err_timeout.
  - A tx_dv coinciding with abort is suppressed.
  - The byte already inside uart_tx completes on its own.
- Simultaneous events:
  - abort has priority over tx_done and over timeout.
  - tx_done in the same cycle as timer expiry counts as success.
- Back-to-back requests: a req_valid in the cycle after FINISH (now IDLE) is accepted. There is no combinational path from req_valid to tx_dv.
- Requests are never queued. While busy, req_ready=0 and req_valid is ignored.
- Frame length in bytes = 4 + len_eff.
- Unloaded (tx_active=0 always, tx_done N cycles after tx_dv) latency from accept to done = (4+len_eff)*(N+2)+1 cycles.

Test Plan:
- status=01, len=0 -> tx_byte sequence A5 01 00 15, exactly 4 tx_dv pulses, one done pulse, req_ready back to 1 the following cycle.
- status=02, len=1, payload[0]=00 -> A5 02 01 00 C3, done pulse once, err_timeout stays 0.
- status=01, req_len=20, 16 distinct payload bytes -> LEN byte 10 (hex), 16 payload bytes then CRC matching a bench CRC8 model over 01,10,payload; 20 tx_dv pulses total.
- tx_active held 1 for 3 extra cycles after tx_done -> no tx_dv until tx_active drops; the bytes still go out in order.
- tx_done withheld after the second byte, TX_TIMEOUT_CYC=100 -> err_timeout pulses exactly 100 cycles after that tx_dv, no done, back in IDLE with req_ready=1.
- abort asserted during payload byte 2, and separately rst pulsed mid-frame -> no further tx_dv, no done, no err_timeout, outputs at reset values, the next request sends a complete correct frame.
